seven_seg_scan_ctrl: RTL and testbench



---
 rtl/seven_seg_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_ctrl
//   Multiplexed scanner for DIGITS common-anode seven-segment digits.
//   Each digit gets a slot of DWELL cycles. The slot opens with BLANK
//   all-dark cycles (anti-ghosting), then the digit is lit for
//   min(bright, DWELL-BLANK) cycles, then it is dark until the slot ends.
//   Digits are scanned most-significant first (idx DIGITS-1 down to 0).
//   Writes land in a pending buffer and are copied to the shadow buffer
//   only on the frame boundary, so a frame is always drawn from one
//   consistent snapshot.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-low reset
//   load        one-cycle strobe; captures the data inputs into pending
//   digit_data  hex nibble per digit, nibble d = bits [4d+3:4d]
//   dp_in       decimal point request per digit, 1 = lit
//   digit_en    per-digit enable, 0 = digit stays dark in its slot
//   bright      lit cycles per slot (clamped to DWELL-BLANK)
//   anode       active-low digit select, registered
//   seg         active-low segments {g,f,e,d,c,b,a}, registered
//   dp_n        active-low decimal point, registered
//   frame_tick  one-cycle pulse after the shadow buffer updates, registered
// ---------------------------------------------------------------------------
module seven_seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 16,
    parameter int BLANK  = 2,
    parameter int BW     = $clog2(DWELL + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digit_data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [BW-1:0]         bright,
    output logic [DIGITS-1:0]     anode,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic                  frame_tick
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [BW-1:0] MAX_ON   = BW'(DWELL - BLANK);

    // Slot position counters
    logic [CW-1:0] cyc;
    logic [IW-1:0] idx;

    // Pending (written by load) and shadow (drawn from) buffers
    logic [4*DIGITS-1:0] pend_data, sh_data;
    logic [DIGITS-1:0]   pend_dp,   sh_dp;
    logic [DIGITS-1:0]   pend_en,   sh_en;
    logic [BW-1:0]       pend_bright, sh_bright;

    logic                boundary;
    logic [BW-1:0]       on_cnt;
    logic                lit;
    logic [DIGITS-1:0]   anode_nxt;
    logic [6:0]          seg_nxt;
    logic                dp_nxt;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        boundary  = (cyc == CYC_LAST) && (idx == '0);
        on_cnt    = (sh_bright > MAX_ON) ? MAX_ON : sh_bright;
        lit       = sh_en[idx] && (int'(cyc) >= BLANK) &&
                    (int'(cyc) < BLANK + int'(on_cnt));
        anode_nxt = '1;
        if (lit) begin
            anode_nxt[idx] = 1'b0;
        end
        // Segments only switch at slot start, while every anode is dark.
        seg_nxt = seg;
        dp_nxt  = dp_n;
        if (cyc == '0) begin
            seg_nxt = hex_decode(sh_data[4*int'(idx) +: 4]);
            dp_nxt  = ~sh_dp[idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc         <= '0;
            idx         <= IDX_LAST;
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            pend_bright <= '0;
            sh_data     <= '0;
            sh_dp       <= '0;
            sh_en       <= '0;
            sh_bright   <= '0;
            anode       <= '1;
            seg         <= 7'h7F;
            dp_n        <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            if (cyc == CYC_LAST) begin
                cyc <= '0;
                idx <= (idx == '0) ? IDX_LAST : idx - IW'(1);
            end else begin
                cyc <= cyc + CW'(1);
            end

            if (load) begin
                pend_data   <= digit_data;
                pend_dp     <= dp_in;
                pend_en     <= digit_en;
                pend_bright <= bright;
            end

            // A load in the boundary cycle bypasses pending straight to shadow.
            if (boundary) begin
                sh_data   <= load ? digit_data : pend_data;
                sh_dp     <= load ? dp_in      : pend_dp;
                sh_en     <= load ? digit_en   : pend_en;
                sh_bright <= load ? bright     : pend_bright;
            end

            anode      <= anode_nxt;
            seg        <= seg_nxt;
            dp_n       <= dp_nxt;
            frame_tick <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan_ctrl
//   Bench for seven_seg_scan_ctrl (DIGITS=4, DWELL=16, BLANK=2).
//   The driver advances a cycle-count reference model of the display and
//   pushes the expected {anode, seg, dp_n, frame_tick} for each cycle into
//   exp_q; the monitor pops one entry after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DWELL  = 16;
    localparam int BLANK  = 2;
    localparam int BW     = $clog2(DWELL + 1);
    localparam int FRAME  = DIGITS * DWELL;
    localparam int W      = DIGITS + 9;

    // ---------------- clock / reset ----------------
    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                load  = 1'b0;
    logic [4*DIGITS-1:0] digit_data = '0;
    logic [DIGITS-1:0]   dp_in = '0;
    logic [DIGITS-1:0]   digit_en = '0;
    logic [BW-1:0]       bright = '0;
    logic [DIGITS-1:0]   anode;
    logic [6:0]          seg;
    logic                dp_n;
    logic                frame_tick;

    always #5 clock = ~clock;

    seven_seg_scan_ctrl #(
        .DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK), .BW(BW)
    ) dut (
        .clock(clock), .reset(reset), .load(load), .digit_data(digit_data),
        .dp_in(dp_in), .digit_en(digit_en), .bright(bright),
        .anode(anode), .seg(seg), .dp_n(dp_n), .frame_tick(frame_tick)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // ---------------- reference model ----------------
    int                  k;          // cycles since reset release
    logic [4*DIGITS-1:0] m_pdata, m_sdata;
    logic [DIGITS-1:0]   m_pdp, m_sdp, m_pen, m_sen;
    int                  m_pbr, m_sbr;
    logic [6:0]          m_seg;
    logic                m_dp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0;
        m_pdata = '0; m_sdata = '0;
        m_pdp = '0; m_sdp = '0; m_pen = '0; m_sen = '0;
        m_pbr = 0; m_sbr = 0;
        m_seg = 7'h7F; m_dp = 1'b1;
    endtask

    // One driven cycle: apply inputs, push what the outputs must show after
    // the coming edge, then advance the model.
    task automatic step(input logic ld, input logic [4*DIGITS-1:0] d,
                        input logic [DIGITS-1:0] dp, input logic [DIGITS-1:0] en,
                        input int br);
        int cyc, digit, on;
        logic [DIGITS-1:0] an;
        logic fb;
        load = ld; digit_data = d; dp_in = dp; digit_en = en; bright = BW'(br);
        cyc   = k % DWELL;
        digit = DIGITS - 1 - (k / DWELL) % DIGITS;
        fb    = (k % FRAME) == FRAME - 1;
        on    = (m_sbr > DWELL - BLANK) ? DWELL - BLANK : m_sbr;
        an    = '1;
        if (m_sen[digit] && cyc >= BLANK && cyc < BLANK + on) an[digit] = 1'b0;
        if (cyc == 0) begin
            m_seg = hex_tab[(m_sdata >> (4 * digit)) & 4'hF];
            m_dp  = ~m_sdp[digit];
        end
        exp_q.push_back({an, m_seg, m_dp, fb});
        if (ld) begin
            m_pdata = d; m_pdp = dp; m_pen = en; m_pbr = br;
        end
        if (fb) begin
            m_sdata = m_pdata; m_sdp = m_pdp; m_sen = m_pen; m_sbr = m_pbr;
        end
        k++;
        @(negedge clock);
    endtask

    task automatic run_to(input int target);
        while (k < target) step(1'b0, '0, '0, '0, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_anode"}, 32'(anode), 32'({DIGITS{1'b1}}));
        chk({tag, "_seg"},   32'(seg), 32'h7F);
        chk({tag, "_dp_n"},  32'(dp_n), 32'd1);
        chk({tag, "_tick"},  32'(frame_tick), 32'd0);
    endtask

    // ---------------- monitor ----------------
    logic [6:0] prev_seg = 7'h7F;
    logic       prev_dp  = 1'b1;

    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("anode", 32'(anode), 32'(e[W-1 -: DIGITS]));
                chk("seg",   32'(seg),   32'(e[8:2]));
                chk("dp_n",  32'(dp_n),  32'(e[1]));
                chk("tick",  32'(frame_tick), 32'(e[0]));
            end
            if (reset) begin
                chk("one_anode_low", 32'($countones(~anode) <= 1), 32'd1);
                if (seg !== prev_seg || dp_n !== prev_dp)
                    chk("seg_change_dark", 32'(anode), 32'({DIGITS{1'b1}}));
            end
            prev_seg = seg;
            prev_dp  = dp_n;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1 reset = 1'b0;
        // Loads during reset must be ignored.
        load = 1'b1; digit_data = 16'hBEEF; digit_en = '1; bright = 5'd9; dp_in = '1;
        repeat (3) @(posedge clock);
        #2 chk_reset_vals("rst_hold");
        @(negedge clock);
        reset = 1'b1;

        // Load 1234 in cycle 3; frame 0 is dark, frame 1 shows it.
        run_to(3);
        step(1'b1, 16'h1234, 4'h0, 4'hF, 14);
        run_to(2 * FRAME);
        step(1'b1, 16'h1234, 4'h0, 4'hF, 5);
        run_to(4 * FRAME);
        step(1'b1, 16'h1234, 4'h0, 4'hF, 0);
        run_to(6 * FRAME);
        step(1'b1, 16'h1234, 4'h0, 4'hF, 15);
        run_to(8 * FRAME);
        step(1'b1, 16'hF0A8, 4'b0001, 4'b1010, 14);
        run_to(10 * FRAME);
        // Mid-frame load, then a boundary-cycle load that must bypass.
        run_to(11 * FRAME + 10);
        step(1'b1, 16'h1111, 4'h0, 4'hF, 14);
        run_to(12 * FRAME - 1);
        step(1'b1, 16'h2222, 4'h0, 4'hF, 14);
        run_to(14 * FRAME);

        // Async reset during an on-cycle of digit 2 (slot cycles 16..31).
        run_to(14 * FRAME + DWELL + 5);
        step(1'b0, '0, '0, '0, 0);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 chk_reset_vals("rst_async");
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        chk_reset_vals("rst_mid");
        reset = 1'b1;
        model_reset();
        run_to(FRAME + 8);

        // Random run.
        repeat (800) begin
            if ($urandom_range(0, 19) == 0)
                step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom),
                     int'($urandom_range(0, (1 << BW) - 1)));
            else
                step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 0);
        end

        @(posedge clock);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
